// File: rtl/ascon_bist_pkg.sv
// ascon_bist_pkg: FSM states, default timing and saturating increment for the Ascon BIST sequencer
package ascon_bist_pkg;
   typedef enum logic [2:0] {IDLE, START, WAIT_ENC, WAIT_DEC, CHECK, GAP, DONE} state_t;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
   localparam int unsigned DEF_GAP_CYCLES = 4;
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
      return (v == max) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/ascon_bist_timer.sv
// ascon_bist_timer: clearable cycle counter with terminal-count flag
module ascon_bist_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic [W-1:0] cnt,
   output logic         tc
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign cnt = cnt_q;
   assign tc = (cnt_q == limit);
endmodule

// File: rtl/ascon_bist_sequencer.sv
// ascon_bist_sequencer: Ascon_Top start/done self-test initiator; ASCON_BIST_LATENCY_EN enables last_latency capture
module ascon_bist_sequencer import ascon_bist_pkg::*; #(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_en,
   input  logic [CNT_W-1:0] num_runs,
   output logic             dut_start,
   input  logic             dut_encryption_done,
   input  logic             dut_decryption_done,
   input  logic             dut_msg_authenticated,
   output logic             busy,
   output logic             campaign_done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             timeout_seen,
   output logic [CNT_W-1:0] last_latency
);
   localparam logic [CNT_W-1:0] ALL1 = '1;
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES - 1);
   state_t state_q, state_d;
   logic run_en_q, enc_q, dec_q, to_q, to_d;
   logic enc_ev, dec_ev, tmr_clr, tmr_en, tmr_tc;
   logic [CNT_W-1:0] num_q, num_d, runs_q, runs_d, pass_q, pass_d, fail_q, fail_d;
   logic [CNT_W-1:0] pass_inc, fail_inc, tmr_cnt, tmr_lim;
   assign enc_ev = dut_encryption_done & ~enc_q;
   assign dec_ev = dut_decryption_done & ~dec_q;
   assign pass_inc = CNT_W'(sat_inc(32'(pass_q), 32'(ALL1)));
   assign fail_inc = CNT_W'(sat_inc(32'(fail_q), 32'(ALL1)));
   assign tmr_lim = (state_q == GAP) ? GAP_LIM : TO_LIM;
   assign tmr_en = (state_q == WAIT_ENC) || (state_q == WAIT_DEC) || (state_q == GAP);
   ascon_bist_timer #(.W(CNT_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .limit (tmr_lim),
      .cnt   (tmr_cnt),
      .tc    (tmr_tc)
   );
   always_comb begin
      state_d = state_q;
      num_d = num_q;
      runs_d = runs_q;
      pass_d = pass_q;
      fail_d = fail_q;
      to_d = to_q;
      tmr_clr = 1'b0;
      if (!run_en) state_d = IDLE;
      else begin
         case (state_q)
            IDLE: if (!run_en_q) begin
               num_d = num_runs;
               runs_d = '0;
               pass_d = '0;
               fail_d = '0;
               to_d = 1'b0;
               state_d = (num_runs == '0) ? DONE : START;
            end
            START: begin
               tmr_clr = 1'b1;
               state_d = WAIT_ENC;
            end
            WAIT_ENC, WAIT_DEC:
               if (dec_ev && (enc_ev || state_q == WAIT_DEC)) state_d = CHECK;
               else if (dec_ev || tmr_tc) begin
                  // dec before enc is a protocol error; otherwise the timer expired
                  fail_d = fail_inc;
                  to_d = to_q | ~dec_ev;
                  runs_d = runs_q + CNT_W'(1);
                  tmr_clr = 1'b1;
                  state_d = GAP;
               end else if (enc_ev) state_d = WAIT_DEC;
            CHECK: begin
               pass_d = dut_msg_authenticated ? pass_inc : pass_q;
               fail_d = dut_msg_authenticated ? fail_q : fail_inc;
               runs_d = runs_q + CNT_W'(1);
               tmr_clr = 1'b1;
               state_d = GAP;
            end
            GAP: if (tmr_tc) state_d = (runs_q == num_q) ? DONE : START;
            DONE: state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         run_en_q <= 1'b0;
         enc_q <= 1'b0;
         dec_q <= 1'b0;
         to_q <= 1'b0;
         num_q <= '0;
         runs_q <= '0;
         pass_q <= '0;
         fail_q <= '0;
      end else begin
         state_q <= state_d;
         run_en_q <= run_en;
         enc_q <= dut_encryption_done;
         dec_q <= dut_decryption_done;
         to_q <= to_d;
         num_q <= num_d;
         runs_q <= runs_d;
         pass_q <= pass_d;
         fail_q <= fail_d;
      end
   end
   assign dut_start = (state_q == START) && run_en;
   assign busy = (state_q != IDLE) && (state_q != DONE);
   assign campaign_done = (state_q == DONE);
   assign pass_cnt = pass_q;
   assign fail_cnt = fail_q;
   assign timeout_seen = to_q;
`ifdef ASCON_BIST_LATENCY_EN
   // timer holds in CHECK, so it equals cycles from the start pulse to the dec event
   logic [CNT_W-1:0] lat_q, lat_d;
   always_comb lat_d = (state_q == CHECK && run_en) ? tmr_cnt : lat_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lat_q <= '0;
      else lat_q <= lat_d;
   end
   assign last_latency = lat_q;
`else
   logic unused_tmr_cnt;
   assign unused_tmr_cnt = ^tmr_cnt;
   assign last_latency = '0;
`endif
endmodule
